// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and constants for the CPU-to-memory bridge
package mem_bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_bridge_timer.sv
// rtl/mem_bridge_timer.sv - WAIT-state cycle counter; expired flags the last permitted WAIT cycle
module mem_bridge_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - stalling CPU bus to valid/ready memory bridge
// Optional WAIT timeout and late-response drop enabled by MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_r,
  input  logic              cpu_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_we;
  logic              r_err;

  logic w_req;
  logic w_misaligned;
  logic w_timeout;
  logic w_drop;

  assign w_req        = cpu_r | cpu_w;
  assign w_misaligned = |(cpu_addr[1:0] & ALIGN_MASK);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic r_drop;

  mem_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  (mem_req_valid & mem_req_ready),
    .i_en     (r_state == ST_WAIT),
    .o_expired(w_timeout)
  );

  // A timed-out access may still be answered later; swallow that one response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop <= 1'b0;
    end else if ((r_state == ST_WAIT) && w_timeout && !mem_rsp_valid) begin
      r_drop <= 1'b1;
    end else if (mem_rsp_valid) begin
      r_drop <= 1'b0;
    end
  end

  assign w_drop = r_drop;
`else
  assign w_timeout = 1'b0;
  assign w_drop    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_misaligned) begin
              r_state <= ST_DONE;
              r_err   <= 1'b1;
            end else begin
              r_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
              r_wdata <= cpu_wdata;
              r_we    <= cpu_w;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_valid && mem_req_ready) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            if (!r_we) begin
              r_rdata <= mem_rsp_rdata;
            end
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall rises in the accepting IDLE cycle itself, but never while reset is held
  assign cpu_stall     = reset & (((r_state == ST_IDLE) & w_req) |
                                  (r_state == ST_REQ) | (r_state == ST_WAIT));
  assign mem_req_valid = (r_state == ST_REQ) & ~w_drop;
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign cpu_rdata     = r_rdata;
  assign cpu_err       = r_err;

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - randomized self-checking bench for mem_bridge against a transaction-level model
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_r = 1'b0, cpu_w = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  // One CPU access against a memory that accepts after rdy_dly cycles and answers rsp_dly cycles later
  task automatic run_access(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                            input logic [31:0] rd, input int exp_stall_cycles);
    logic [31:0] exp_addr;
    int stall_cnt;
    exp_addr = {addr[31:2], 2'b00};
    stall_cnt = 0;
    @(negedge clk);
    cpu_r = r; cpu_w = w; cpu_addr = addr; cpu_wdata = wd;
    #1;
    n_checks++;
    if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL idle_stall: got %b expected 1", cpu_stall); end
    if (addr[1:0] != 2'b00) begin
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL mis_valid: got %b expected 0", mem_req_valid); end
      n_checks++;
      if (cpu_err !== 1'b1) begin n_errors++; $display("FAIL mis_err: got %b expected 1", cpu_err); end
      n_checks++;
      if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL mis_stall: got %b expected 0", cpu_stall); end
      n_checks++;
      if (cpu_rdata !== exp_rdata) begin n_errors++; $display("FAIL mis_rdata: got %h expected %h", cpu_rdata, exp_rdata); end
      cpu_r = 1'b0; cpu_w = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cpu_err !== 1'b0) begin n_errors++; $display("FAIL mis_err_pulse: got %b expected 0", cpu_err); end
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = ($urandom_range(0, 2) == 0);
        mem_rsp_rdata = $urandom;
        if (cpu_stall === 1'b1) stall_cnt++;
        n_checks++;
        if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL req_valid: got %b expected 1", mem_req_valid); end
        n_checks++;
        if ({mem_req_we, mem_req_addr, mem_req_wdata} !== {w, exp_addr, wd}) begin
          n_errors++;
          $display("FAIL req_fields: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                   mem_req_we, mem_req_addr, mem_req_wdata, w, exp_addr, wd);
        end
        if (i == rdy_dly) mem_req_ready = 1'b1;
      end
      for (int j = 0; j <= rsp_dly; j++) begin
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (cpu_stall === 1'b1) stall_cnt++;
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL wait_valid: got %b expected 0", mem_req_valid); end
        if (j == rsp_dly) begin mem_rsp_valid = 1'b1; mem_rsp_rdata = rd; end
      end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (!w) exp_rdata = rd;
      n_checks++;
      if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL done_stall: got %b expected 0", cpu_stall); end
      n_checks++;
      if (cpu_err !== 1'b0) begin n_errors++; $display("FAIL done_err: got %b expected 0", cpu_err); end
      n_checks++;
      if (cpu_rdata !== exp_rdata) begin n_errors++; $display("FAIL done_rdata: got %h expected %h", cpu_rdata, exp_rdata); end
      n_checks++;
      if (stall_cnt != exp_stall_cycles) begin n_errors++; $display("FAIL stall_cycles: got %0d expected %0d", stall_cnt, exp_stall_cycles); end
      cpu_r = 1'b0; cpu_w = 1'b0;
    end
  endtask

  task automatic test_reset;
    cpu_r = 1'b1;
    cpu_addr = 32'h10;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cpu_rdata, cpu_err, cpu_stall, mem_req_valid} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdata=%h err=%b stall=%b valid=%b expected 0", cpu_rdata, cpu_err, cpu_stall, mem_req_valid);
    end
    n_checks++;
    if ({mem_req_we, mem_req_addr, mem_req_wdata} !== 65'h0) begin
      n_errors++;
      $display("FAIL reset_fields: got we=%b addr=%h wdata=%h expected 0", mem_req_we, mem_req_addr, mem_req_wdata);
    end
    cpu_r = 1'b0;
    reset = 1'b1;
    exp_rdata = '0;
  endtask

  task automatic test_read_basic;
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF, 2);
  endtask

  task automatic test_write_delayed;
    run_access(1'b0, 1'b1, 32'h20, 32'h12345678, 3, 0, 32'h5555_5555, 5);
  endtask

  task automatic test_misaligned;
    run_access(1'b1, 1'b0, 32'h13, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_both_high;
    run_access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 1, 1, 32'h0BAD0BAD, 4);
  endtask

  task automatic test_back_to_back;
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 32'h11112222, 2);
    run_access(1'b0, 1'b1, 32'h104, 32'h33334444, 0, 2, 32'h0, 4);
    run_access(1'b1, 1'b0, 32'h108, 32'h0, 2, 0, 32'h55556666, 4);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic r, w;
      logic [31:0] a;
      int rd_d, rs_d;
      r = $urandom_range(0, 1);
      w = (r == 1'b0) ? 1'b1 : logic'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      rd_d = $urandom_range(0, 3);
      rs_d = $urandom_range(0, 3);
      run_access(r, w, a, $urandom, rd_d, rs_d, $urandom, rd_d + rs_d + 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cpu_r = 1'b1; cpu_addr = 32'h60;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1 reset = 1'b0;
    exp_rdata = '0;
    #1;
    n_checks++;
    if ({cpu_rdata, cpu_err, cpu_stall, mem_req_valid} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL midreset_outputs: got rdata=%h err=%b stall=%b valid=%b expected 0", cpu_rdata, cpu_err, cpu_stall, mem_req_valid);
    end
    n_checks++;
    if (mem_req_addr !== 32'h0) begin n_errors++; $display("FAIL midreset_addr: got %h expected 0", mem_req_addr); end
    @(negedge clk);
    cpu_r = 1'b0;
    reset = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFEEDFACE;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    n_checks++;
    if ({cpu_rdata, cpu_err, cpu_stall, mem_req_valid} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL late_rsp_after_reset: got rdata=%h err=%b stall=%b valid=%b expected 0", cpu_rdata, cpu_err, cpu_stall, mem_req_valid);
    end
    run_access(1'b1, 1'b0, 32'h64, 32'h0, 0, 0, 32'h7777_8888, 2);
  endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    @(negedge clk);
    cpu_r = 1'b1; cpu_addr = 32'h50;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({cpu_stall, cpu_err} !== 2'b10) begin n_errors++; $display("FAIL timeout_wait: got stall=%b err=%b expected 1 0", cpu_stall, cpu_err); end
      @(negedge clk);
    end
    n_checks++;
    if ({cpu_stall, cpu_err} !== 2'b01) begin n_errors++; $display("FAIL timeout_done: got stall=%b err=%b expected 0 1", cpu_stall, cpu_err); end
    n_checks++;
    if (cpu_rdata !== exp_rdata) begin n_errors++; $display("FAIL timeout_rdata: got %h expected %h", cpu_rdata, exp_rdata); end
    cpu_r = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000AAAA;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    run_access(1'b1, 1'b0, 32'h54, 32'h0, 0, 0, 32'h9999_0001, 2);
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_delayed();
    test_misaligned();
    test_both_high();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef MEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
